// File: rtl/multi_edge_detector.sv
// Multi-channel synchronised edge detector with retriggerable hold windows.
// Define DET_GLITCH_FILTER_EN to add a FILT-cycle stability filter behind the synchroniser.
//
// state  | meaning
// IDLE   | no window open, waiting for an accepted edge
// ACTIVE | window open, hold counter running down to zero

module multi_edge_detector #(
    parameter int CH   = 4,
    parameter int HOLD = 10,
    parameter int SYNC = 2,
    parameter int FILT = 3
) (
    input  logic          det_clk,
    input  logic          det_rst_n,
    input  logic [CH-1:0] det_input,
    input  logic [1:0]    det_mode,
    input  logic          det_clr,
    output logic [CH-1:0] det_pulse,
    output logic [CH-1:0] det_output,
    output logic [CH-1:0] det_edge_type
);

`ifdef DET_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    // Startup blanking also covers the filter delay so a level held through reset never fires.
    localparam int             GUARD    = SYNC + 1 + (FILT_ON ? FILT : 0);
    localparam logic [4:0]     GUARD_TC = 5'(GUARD);
    localparam logic [7:0]     HOLD_M1  = 8'(HOLD - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [CH-1:0] sync_q [SYNC];
    logic [CH-1:0] samp;
    logic [CH-1:0] prev_q;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] accept;
    logic [4:0]    guard_q;
    logic          armed;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [7:0]    cnt_q   [CH];
    logic [7:0]    cnt_d   [CH];
    logic [CH-1:0] pulse_q;
    logic [CH-1:0] pulse_d;
    logic [CH-1:0] type_q;
    logic [CH-1:0] type_d;

    always_ff @(posedge det_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= det_input;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef DET_GLITCH_FILTER_EN
    logic [CH-1:0] filt_q;
    logic [3:0]    fcnt_q [CH];

    always_ff @(posedge det_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            filt_q <= '0;
            for (int c = 0; c < CH; c++) fcnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (sync_q[SYNC-1][c] != filt_q[c]) begin
                    if (fcnt_q[c] == 4'(FILT - 1)) begin
                        filt_q[c] <= sync_q[SYNC-1][c];
                        fcnt_q[c] <= '0;
                    end else begin
                        fcnt_q[c] <= fcnt_q[c] + 4'd1;
                    end
                end else begin
                    fcnt_q[c] <= '0;
                end
            end
        end
    end

    assign samp = filt_q;
`else
    assign samp = sync_q[SYNC-1];
`endif

    always_ff @(posedge det_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            prev_q  <= '0;
            guard_q <= '0;
        end else begin
            prev_q <= samp;
            if (!armed) guard_q <= guard_q + 5'd1;
        end
    end

    assign armed  = (guard_q == GUARD_TC);
    assign rise   = samp & ~prev_q;
    assign fall   = ~samp & prev_q;
    assign accept = armed ? ((rise & {CH{det_mode[0]}}) | (fall & {CH{det_mode[1]}})) : '0;

    always_ff @(posedge det_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            pulse_q <= '0;
            type_q  <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            pulse_q <= pulse_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        pulse_d = '0;
        type_d  = type_q;
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            if (det_clr) begin
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
                type_d[c]  = 1'b0;
            end else if (accept[c]) begin
                // Retrigger from either state, even on the terminal-count cycle.
                state_d[c] = ACTIVE;
                cnt_d[c]   = HOLD_M1;
                pulse_d[c] = 1'b1;
                type_d[c]  = rise[c];
            end else if (state_q[c] == ACTIVE) begin
                if (cnt_q[c] == 8'd0) state_d[c] = IDLE;
                else                  cnt_d[c]   = cnt_q[c] - 8'd1;
            end
        end
    end

    always_comb begin
        det_output = '0;
        for (int c = 0; c < CH; c++) det_output[c] = (state_q[c] == ACTIVE);
        det_pulse     = pulse_q;
        det_edge_type = type_q;
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: reference model feeds a scoreboard queue,
// plus directed window/pulse measurements. Honours DET_GLITCH_FILTER_EN.

module tb_multi_edge_detector;

    localparam int CH   = 4;
    localparam int HOLD = 10;
    localparam int SYNC = 2;
    localparam int FILT = 3;
`ifdef DET_GLITCH_FILTER_EN
    localparam int FLAT = FILT;
`else
    localparam int FLAT = 0;
`endif
    localparam int GUARD = SYNC + 1 + FLAT;

    logic          det_clk   = 1'b0;
    logic          det_rst_n = 1'b0;
    logic [CH-1:0] det_input = '0;
    logic [1:0]    det_mode  = 2'b00;
    logic          det_clr   = 1'b0;
    logic [CH-1:0] det_pulse;
    logic [CH-1:0] det_output;
    logic [CH-1:0] det_edge_type;

    multi_edge_detector #(.CH(CH), .HOLD(HOLD), .SYNC(SYNC), .FILT(FILT)) dut (
        .det_clk       (det_clk),
        .det_rst_n     (det_rst_n),
        .det_input     (det_input),
        .det_mode      (det_mode),
        .det_clr       (det_clr),
        .det_pulse     (det_pulse),
        .det_output    (det_output),
        .det_edge_type (det_edge_type)
    );

    always #5 det_clk = ~det_clk;

    typedef struct packed {
        logic [CH-1:0] pulse;
        logic [CH-1:0] out;
        logic [CH-1:0] etype;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [CH-1:0] din;
    logic [CH-1:0] m_sync [SYNC];
    logic [CH-1:0] m_p;
    logic [CH-1:0] m_type;
    int            m_rem [CH];
    int            m_guard;
`ifdef DET_GLITCH_FILTER_EN
    logic [CH-1:0] m_f;
    int            m_fc [CH];
`endif

    int step_idx;
    int pulse_cnt [CH];
    int high_cnt [CH];
    int first_pulse [CH];
    int first_high [CH];
    int last_high [CH];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        m_p     = '0;
        m_type  = '0;
        m_guard = 0;
        for (int c = 0; c < CH; c++) m_rem[c] = 0;
`ifdef DET_GLITCH_FILTER_EN
        m_f = '0;
        for (int c = 0; c < CH; c++) m_fc[c] = 0;
`endif
        sb_q.delete();
    endtask

    // Predicts the outputs visible just after the next rising edge.
    task automatic model_edge(input logic [CH-1:0] in, input logic [1:0] mode, input logic clr);
        exp_t          e;
        logic [CH-1:0] s;
        logic          r;
        logic          f;
        logic          acc;
`ifdef DET_GLITCH_FILTER_EN
        s = m_f;
`else
        s = m_sync[SYNC-1];
`endif
        e = '0;
        for (int c = 0; c < CH; c++) begin
            r   = s[c] && !m_p[c];
            f   = !s[c] && m_p[c];
            acc = (m_guard >= GUARD) &&
                  ((r && (mode == 2'b01 || mode == 2'b11)) || (f && (mode == 2'b10 || mode == 2'b11)));
            if (clr) begin
                m_rem[c]  = 0;
                m_type[c] = 1'b0;
            end else if (acc) begin
                m_rem[c]   = HOLD;
                m_type[c]  = r;
                e.pulse[c] = 1'b1;
            end else if (m_rem[c] > 0) begin
                m_rem[c]--;
            end
            e.out[c] = (m_rem[c] > 0);
        end
        e.etype = m_type;
        sb_q.push_back(e);
`ifdef DET_GLITCH_FILTER_EN
        for (int c = 0; c < CH; c++) begin
            if (m_sync[SYNC-1][c] != m_f[c]) begin
                m_fc[c]++;
                if (m_fc[c] == FILT) begin
                    m_f[c]  = m_sync[SYNC-1][c];
                    m_fc[c] = 0;
                end
            end else begin
                m_fc[c] = 0;
            end
        end
`endif
        m_p = s;
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = in;
        if (m_guard < GUARD) m_guard++;
    endtask

    task automatic obs_clear();
        step_idx = 0;
        for (int c = 0; c < CH; c++) begin
            pulse_cnt[c]   = 0;
            high_cnt[c]    = 0;
            first_pulse[c] = -1;
            first_high[c]  = -1;
            last_high[c]   = -1;
        end
    endtask

    task automatic step(input logic [CH-1:0] in, input logic [1:0] mode, input logic clr);
        exp_t e;
        det_input = in;
        det_mode  = mode;
        det_clr   = clr;
        model_edge(in, mode, clr);
        @(posedge det_clk);
        #1;
        e = sb_q.pop_front();
        check_val($sformatf("sb_pulse@%0d", step_idx), 32'(det_pulse), 32'(e.pulse));
        check_val($sformatf("sb_output@%0d", step_idx), 32'(det_output), 32'(e.out));
        check_val($sformatf("sb_etype@%0d", step_idx), 32'(det_edge_type), 32'(e.etype));
        for (int c = 0; c < CH; c++) begin
            if (det_pulse[c] === 1'b1) begin
                pulse_cnt[c]++;
                if (first_pulse[c] < 0) first_pulse[c] = step_idx;
            end
            if (det_output[c] === 1'b1) begin
                high_cnt[c]++;
                if (first_high[c] < 0) first_high[c] = step_idx;
                last_high[c] = step_idx;
            end
        end
        step_idx++;
    endtask

    task automatic do_reset(input logic [CH-1:0] in);
        det_rst_n = 1'b0;
        det_input = in;
        din       = in;
        det_clr   = 1'b0;
        model_reset();
        #1;
        check_val("rst_pulse", 32'(det_pulse), 0);
        check_val("rst_output", 32'(det_output), 0);
        check_val("rst_etype", 32'(det_edge_type), 0);
        repeat (2) @(posedge det_clk);
        #1;
        det_rst_n = 1'b1;
    endtask

    function automatic int sum(input int a [CH]);
        int t = 0;
        for (int c = 0; c < CH; c++) t += a[c];
        return t;
    endfunction

    initial begin
        din = '0;
        obs_clear();
        do_reset(4'h0);
        repeat (5) step(din, 2'b11, 1'b0);

        // Falling-only mode on ch0: one window, rising edge ignored.
        din[0] = 1'b1;
        repeat (15) step(din, 2'b10, 1'b0);
        obs_clear();
        din[0] = 1'b0;
        repeat (14) step(din, 2'b10, 1'b0);
        check_val("fall_pulses", pulse_cnt[0], 1);
        check_val("fall_latency", first_pulse[0], 2 + FLAT);
        check_val("fall_high", high_cnt[0], HOLD);
        check_val("fall_etype", 32'(det_edge_type[0]), 0);
        obs_clear();
        din[0] = 1'b1;
        repeat (14) step(din, 2'b10, 1'b0);
        check_val("rise_ignored", pulse_cnt[0] + high_cnt[0], 0);

        // Mode 00 swallows edges on every channel.
        obs_clear();
        step(4'hF, 2'b00, 1'b0);
        step(4'h0, 2'b00, 1'b0);
        step(4'hF, 2'b00, 1'b0);
        step(4'h0, 2'b00, 1'b0);
        din = 4'hF;
        repeat (8) step(din, 2'b00, 1'b0);
        check_val("mode00_pulses", sum(pulse_cnt), 0);
        check_val("mode00_high", sum(high_cnt), 0);

        // Both edges on ch2, five cycles apart: retrigger stretches the window.
        obs_clear();
        din[2] = 1'b0;
        repeat (5) step(din, 2'b11, 1'b0);
        din[2] = 1'b1;
        repeat (20) step(din, 2'b11, 1'b0);
        check_val("retrig_pulses", pulse_cnt[2], 2);
        check_val("retrig_high", high_cnt[2], 15);
        check_val("retrig_span", last_high[2] - first_high[2] + 1, 15);
        check_val("retrig_etype", 32'(det_edge_type[2]), 1);

        // Synchronous clear in the fourth window cycle on ch1.
        din[1] = 1'b0;
        repeat (15) step(din, 2'b11, 1'b0);
        obs_clear();
        din[1] = 1'b1;
        repeat (6) step(din, 2'b11, 1'b0);
        check_val("clr_etype_pre", 32'(det_edge_type[1]), 1);
        step(din, 2'b11, 1'b1);
        check_val("clr_output", 32'(det_output[1]), 0);
        check_val("clr_etype", 32'(det_edge_type[1]), 0);
        repeat (10) step(din, 2'b11, 1'b0);
        check_val("clr_pulses", pulse_cnt[1], 1);
        check_val("clr_high", high_cnt[1], 4);

        // Mode dropped to 00 mid-window: the open window still runs full length.
        obs_clear();
        din[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) din[3] = 1'b1;
            step(din, (i < 2 + FLAT + 2) ? 2'b10 : 2'b00, 1'b0);
        end
        check_val("modechg_pulses", pulse_cnt[3], 1);
        check_val("modechg_high", high_cnt[3], HOLD);

        // Short and long low excursions on ch3.
        repeat (5) step(din, 2'b10, 1'b0);
        obs_clear();
        din[3] = 1'b0;
        repeat (2) step(din, 2'b10, 1'b0);
        din[3] = 1'b1;
        repeat (16) step(din, 2'b10, 1'b0);
        check_val("glitch2_pulses", pulse_cnt[3], (FLAT > 2) ? 0 : 1);
        obs_clear();
        din[3] = 1'b0;
        repeat (4) step(din, 2'b10, 1'b0);
        din[3] = 1'b1;
        repeat (18) step(din, 2'b10, 1'b0);
        check_val("glitch4_pulses", pulse_cnt[3], 1);
        check_val("glitch4_latency", first_pulse[3], 2 + FLAT);

        // Reset mid-window drops det_output without a clock, then input held high through reset.
        din[0] = 1'b0;
        repeat (4 + FLAT) step(din, 2'b11, 1'b0);
        check_val("midwin_open", 32'(det_output[0]), 1);
        det_rst_n = 1'b0;
        #1;
        check_val("async_drop", 32'(det_output), 0);
        do_reset(4'hF);
        obs_clear();
        repeat (20) step(din, 2'b11, 1'b0);
        check_val("held_high_pulses", sum(pulse_cnt), 0);
        check_val("held_high_out", sum(high_cnt), 0);

        // Random traffic against the model.
        for (int i = 0; i < 120; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(5) == 0) din[c] = ~din[c];
            step(din, 2'($urandom_range(3)), ($urandom_range(15) == 0));
        end

        check_val("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter HOLD, default 10: detection-window length in det_clk cycles, 1..255.
REQ-003 Parameter SYNC, default 2: synchroniser depth per channel, 2..4.
REQ-004 Parameter FILT, default 3: glitch-filter stability count, 1..15; used only when DET_GLITCH_FILTER_EN is defined.
REQ-005 det_clk  input  1  sole clock; all flops on its rising edge.
REQ-006 det_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 det_input  input  CH  asynchronous channel inputs.
REQ-008 det_mode  input  2  edge qualification, all channels: 00 none, 01 rising, 10 falling, 11 both.
REQ-009 det_clr  input  1  synchronous clear of all channel windows.
REQ-010 det_pulse  output  CH  one-cycle pulse per accepted edge.
REQ-011 det_output  output  CH  level, high while the channel window is open.
REQ-012 det_edge_type  output  CH  polarity of the last accepted edge: 1 rising, 0 falling.

Function
REQ-013 Each channel SHALL pass det_input through a SYNC-flop synchroniser; the last stage is the sampled value s.
REQ-014 An edge is s differing from the registered previous value p: rising = s & ~p, falling = ~s & p; p loads s every cycle.
REQ-015 An edge is accepted only when its polarity matches det_mode; mode 00 accepts none.
REQ-016 Per-channel FSM with states IDLE and ACTIVE and an 8-bit down-counter.
REQ-017 IDLE + accepted edge -> ACTIVE, counter loaded with HOLD-1, det_pulse high one cycle, det_edge_type updated.
REQ-018 ACTIVE, counter nonzero, no accepted edge -> decrement; counter zero, no accepted edge -> IDLE.
REQ-019 ACTIVE + accepted edge (including when counter is zero) -> retrigger: counter reloaded with HOLD-1, det_pulse high one cycle, det_edge_type updated, state stays ACTIVE.
REQ-020 det_output = (state == ACTIVE); a single accepted edge gives exactly HOLD cycles high.
REQ-021 Latency: det_pulse and det_output rise SYNC+1 det_clk edges after the input change, counting the capturing edge as the first (plus FILT when filtering).
REQ-022 det_mode changes apply from the next cycle; open windows always run to completion.
REQ-023 det_clr high: every channel goes to IDLE, counter 0, det_pulse 0, det_edge_type 0 at the next edge. Edges in that cycle are discarded. p keeps tracking s and the synchroniser is unaffected.
REQ-024 Channels are fully independent; simultaneous edges on several channels are all handled in the same cycle.

Reset
REQ-025 det_rst_n low SHALL clear all flops asynchronously: synchronisers, p, state, counters, det_pulse, det_output, det_edge_type = 0.
REQ-026 For the first SYNC+1 cycles after det_rst_n deasserts, edge acceptance SHALL be suppressed while p tracks s. An input held high through reset produces no pulse.
REQ-027 Reset asserted mid-window SHALL drop det_output immediately, without waiting for a clock.

Configuration
REQ-028 With DET_GLITCH_FILTER_EN defined, s SHALL be replaced by a filtered value that changes only after the synchroniser output holds the new level for FILT consecutive cycles. Shorter excursions are ignored and latency grows by FILT.
REQ-029 Without DET_GLITCH_FILTER_EN, no filter logic exists, FILT is ignored and s is the synchroniser output.

Verification (CH=4, HOLD=10, SYNC=2, FILT=3)
REQ-030 mode=10, det_input[0] 1->0 at edge n -> det_pulse[0] high one cycle after edge n+2, det_output[0] high 10 cycles, det_edge_type[0]=0; a later 0->1 produces nothing.
REQ-031 mode=11, fall then rise 5 cycles apart on ch2 -> two pulses, det_output[2] high 15 contiguous cycles, final det_edge_type[2]=1.
REQ-032 det_clr pulsed in window cycle 4 on ch1 -> det_output[1] low next cycle, no pulse, det_edge_type[1]=0.
REQ-033 det_input=4'hF held through reset release, mode=11 -> no det_pulse for 20 cycles.
REQ-034 Filter defined: 2-cycle low glitch on ch3, mode=10 -> no pulse; 4-cycle low -> pulse 6 edges after the input change (SYNC+1+FILT). Filter undefined: 2-cycle glitch -> pulse after 3 edges.
REQ-035 mode=00 with edges on all channels -> no activity; mode 10->00 at window cycle 3 -> that window still lasts 10 cycles.
